// File: rtl/ram_16_bist_ctrl.sv
// rtl/ram_16_bist_ctrl.sv - March-style write/read/compare BIST controller for a 16x16 single-port RAM
`timescale 1ns/1ps
module ram_16_bist_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int RD_LATENCY  = 1,
    parameter int INVERT_PASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [4:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              ram_write_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [1:0]        DRAIN_LAST = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;
    localparam logic [4:0]        ERR_MAX    = 5'd31;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_pat;
    logic              r_pass_no;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_drain_cnt;

    logic [DATA_W-1:0] w_cur_pat;
    logic              w_issue;
    logic              w_last_addr;
    logic              w_cmp_valid;
    logic [ADDR_W-1:0] w_cmp_addr;
    logic              w_mismatch;
    logic [4:0]        w_err_nxt;
    logic              w_end_pass;

    // The RAM port and status flags are pure decodes of the FSM state so reset clears them at once
    assign busy           = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);
    assign ram_write_data = (r_state == S_WRITE);
    assign ram_address    = r_addr;
    assign ram_data_in    = w_cur_pat;

    assign w_cur_pat   = r_pass_no ? ~r_pat : r_pat;
    assign w_issue     = (r_state == S_READ);
    assign w_last_addr = (r_addr == LAST_ADDR);

    generate
        if (RD_LATENCY == 0) begin : g_cmp_comb
            // Zero-latency RAM: data belongs to the address issued this cycle
            assign w_cmp_valid = w_issue;
            assign w_cmp_addr  = r_addr;
        end else begin : g_cmp_pipe
            logic [RD_LATENCY-1:0]             r_vld_sr;
            logic [RD_LATENCY-1:0][ADDR_W-1:0] r_addr_sr;

            // Delay each issued read address by the RAM latency so compares line up with data
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_sr  <= '0;
                    r_addr_sr <= '0;
                end else begin
                    r_vld_sr[0]  <= w_issue;
                    r_addr_sr[0] <= r_addr;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        r_vld_sr[i]  <= r_vld_sr[i-1];
                        r_addr_sr[i] <= r_addr_sr[i-1];
                    end
                end
            end

            assign w_cmp_valid = r_vld_sr[RD_LATENCY-1];
            assign w_cmp_addr  = r_addr_sr[RD_LATENCY-1];
        end
    endgenerate

    assign w_mismatch = w_cmp_valid && (ram_data_out != w_cur_pat);
    assign w_err_nxt  = (w_mismatch && (err_count != ERR_MAX)) ? err_count + 5'd1 : err_count;

    // A pass ends on the last read when there is nothing in flight, otherwise on the last drain cycle
    assign w_end_pass = ((RD_LATENCY == 0) && (r_state == S_READ) && w_last_addr) ||
                        ((r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST));

    // Sequencer plus result bookkeeping; the test always runs to completion regardless of errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_pass_no   <= 1'b0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pat     <= pattern;
                        r_pass_no <= 1'b0;
                        r_addr    <= '0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_last_addr) begin
                        r_addr  <= '0;
                        r_state <= S_READ;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_READ: begin
                    if (w_last_addr) begin
                        if (RD_LATENCY > 0) begin
                            r_drain_cnt <= '0;
                            r_state     <= S_DRAIN;
                        end
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_end_pass) begin
                if ((INVERT_PASS != 0) && !r_pass_no) begin
                    r_pass_no <= 1'b1;
                    r_addr    <= '0;
                    r_state   <= S_WRITE;
                end else begin
                    pass    <= (w_err_nxt == 5'd0);
                    r_state <= S_DONE;
                end
            end

            if (w_mismatch) begin
                err_count <= w_err_nxt;
                if (err_count == 5'd0) begin
                    fail_addr <= w_cmp_addr;
                    fail_data <= ram_data_out;
                end
            end
        end
    end

endmodule
